// File: rtl/pulse_meas_pkg.sv
// pulse_meas_pkg
//   Shared definitions for the pulse measurement block: register byte
//   addresses, version, status/config bit positions and the FSM state type.
package pulse_meas_pkg;

    localparam logic [7:0] VERSION = 8'd1;

    // Register byte addresses (multi-byte fields are little-endian)
    localparam logic [4:0] ADDR_RESET   = 5'd0;
    localparam logic [4:0] ADDR_START   = 5'd1;
    localparam logic [4:0] ADDR_CONF    = 5'd2;
    localparam logic [4:0] ADDR_TIMEOUT = 5'd3;
    localparam logic [4:0] ADDR_NUM     = 5'd7;
    localparam logic [4:0] ADDR_DELAY   = 5'd9;
    localparam logic [4:0] ADDR_WIDTH   = 5'd13;
    localparam logic [4:0] ADDR_PERIOD  = 5'd17;
    localparam logic [4:0] ADDR_COUNT   = 5'd21;

    // Status byte bit positions
    localparam int STAT_DONE = 0;
    localparam int STAT_TOUT = 1;
    localparam int STAT_OVF  = 2;

    // Config byte bit positions
    localparam int CONF_EN_BIT  = 0;
    localparam int CONF_INV_BIT = 1;

    // START write delay: vld_pipe[START_STAGES:0] gives three cycles, the
    // same latency as the synchroniser + edge-detect path.
    localparam int START_STAGES = 2;

    // Edge-sync channel indices
    localparam int CH_PULSE = 0;
    localparam int CH_EXT   = 1;
    localparam int NUM_CH   = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        DONE_ST   = 2'd3
    } meas_state_t;

endpackage

// File: rtl/pulse_meas_core_edge_sync.sv
// pulse_edge_sync
//   Two-flop synchroniser followed by one edge-detect register.
//   An input change is visible on rise/fall in the cycle ending with the
//   third clock edge after the change.
// Ports:
//   clk   - clock
//   rst_n - async active-low reset
//   din   - asynchronous input
//   rise  - one-cycle pulse on a synchronised 0->1 transition
//   fall  - one-cycle pulse on a synchronised 1->0 transition
module pulse_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            last_q <= sync_q[1];
        end
    end

    assign rise = sync_q[1] & ~last_q;
    assign fall = ~sync_q[1] & last_q;

endmodule

// File: rtl/pulse_meas_core.sv
// pulse_meas_core
//   Bus-mapped pulse measurement. After an arm (START write or EXT_START
//   rising edge with CONF_EN) it measures delay to the first rising edge,
//   width of the first pulse, period of the last two pulses and the number
//   of rising edges, all in BUS_CLK cycles.
// Ports:
//   BUS_CLK, BUS_RST_N          - clock, async active-low reset
//   BUS_ADD/BUS_DATA_IN/BUS_WR  - byte register writes
//   BUS_RD/BUS_DATA_OUT         - byte register reads, data one cycle later
//   PULSE_IN                    - asynchronous pulse to measure
//   EXT_START                   - asynchronous external arm (rising edge)
//   BUSY                        - measurement in progress
module pulse_meas_core
    import pulse_meas_pkg::*;
#(
    parameter int ABUSWIDTH = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_WR,
    input  logic                 BUS_RD,
    input  logic                 PULSE_IN,
    input  logic                 EXT_START,
    output logic                 BUSY
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // ---------------- bus decode ----------------
    logic [4:0] addr;
    logic       addr_hit;
    logic       wr_en, soft_rst, start_wr;

    assign addr     = BUS_ADD[4:0];
    assign addr_hit = (BUS_ADD >> 5) == '0;
    assign wr_en    = BUS_WR & addr_hit;
    assign soft_rst = wr_en && (addr == ADDR_RESET);
    assign start_wr = wr_en && (addr == ADDR_START);

    // ---------------- configuration ----------------
    logic        conf_en, conf_inv;
    logic [31:0] conf_timeout;
    logic [15:0] conf_num;
    logic [15:0] num_eff;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            conf_en      <= 1'b0;
            conf_inv     <= 1'b0;
            conf_timeout <= '0;
            conf_num     <= '0;
        end else if (soft_rst) begin
            conf_en      <= 1'b0;
            conf_inv     <= 1'b0;
            conf_timeout <= '0;
            conf_num     <= '0;
        end else if (wr_en) begin
            case (addr)
                ADDR_CONF: begin
                    conf_en  <= BUS_DATA_IN[CONF_EN_BIT];
                    conf_inv <= BUS_DATA_IN[CONF_INV_BIT];
                end
                ADDR_TIMEOUT:         conf_timeout[7:0]   <= BUS_DATA_IN;
                ADDR_TIMEOUT + 5'd1:  conf_timeout[15:8]  <= BUS_DATA_IN;
                ADDR_TIMEOUT + 5'd2:  conf_timeout[23:16] <= BUS_DATA_IN;
                ADDR_TIMEOUT + 5'd3:  conf_timeout[31:24] <= BUS_DATA_IN;
                ADDR_NUM:             conf_num[7:0]       <= BUS_DATA_IN;
                ADDR_NUM + 5'd1:      conf_num[15:8]      <= BUS_DATA_IN;
                default: ;
            endcase
        end
    end

    assign num_eff = (conf_num == '0) ? 16'd1 : conf_num;

    // ---------------- input conditioning ----------------
    logic [NUM_CH-1:0] sync_din, sync_rise, sync_fall;
    logic              unused_ext_fall;

    assign sync_din[CH_PULSE] = PULSE_IN ^ conf_inv;
    assign sync_din[CH_EXT]   = EXT_START;
    assign unused_ext_fall    = sync_fall[CH_EXT];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
        pulse_edge_sync u_sync (
            .clk   (BUS_CLK),
            .rst_n (BUS_RST_N),
            .din   (sync_din[i]),
            .rise  (sync_rise[i]),
            .fall  (sync_fall[i])
        );
    end

    // START is delayed to line up with the synchronised input edges, so
    // DELAY is measured from the bus write just as from EXT_START.
    logic [START_STAGES:0] vld_pipe;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N)    vld_pipe <= '0;
        else if (soft_rst) vld_pipe <= '0;
        else               vld_pipe <= {vld_pipe[START_STAGES-1:0], start_wr};
    end

    logic arm, p_rise, p_fall;
    assign arm    = vld_pipe[START_STAGES] | (sync_rise[CH_EXT] & conf_en);
    assign p_rise = sync_rise[CH_PULSE];
    assign p_fall = sync_fall[CH_PULSE];

    // ---------------- FSM ----------------
    meas_state_t state_q, state_nxt;
    logic [CNT_WIDTH-1:0] gcnt_q, pcnt_q, wcnt_q;
    logic [CNT_WIDTH-1:0] delay_q, width_q, period_q;
    logic [15:0]          count_q;
    logic                 done_q, tout_q, ovf_q;
    logic                 tout_hit, rec_rise, rec_fall, set_tout;

    assign tout_hit = (conf_timeout != '0) && (gcnt_q == CNT_WIDTH'(conf_timeout));

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N)    state_q <= IDLE;
        else if (soft_rst) state_q <= IDLE;
        else               state_q <= state_nxt;
    end

    // Arm overrides everything; an edge seen together with the timeout is
    // still recorded before the timeout moves the FSM to DONE_ST.
    always_comb begin
        state_nxt = state_q;
        rec_rise  = 1'b0;
        rec_fall  = 1'b0;
        set_tout  = 1'b0;
        if (arm) begin
            state_nxt = WAIT_RISE;
        end else begin
            unique case (state_q)
                IDLE: ;
                WAIT_RISE: begin
                    if (p_rise) begin
                        rec_rise  = 1'b1;
                        state_nxt = HIGH;
                    end
                    if (tout_hit) begin
                        set_tout  = 1'b1;
                        state_nxt = DONE_ST;
                    end
                end
                HIGH: begin
                    if (p_fall) begin
                        rec_fall  = 1'b1;
                        state_nxt = (count_q == num_eff) ? DONE_ST : WAIT_RISE;
                    end
                    if (tout_hit) begin
                        set_tout  = 1'b1;
                        state_nxt = DONE_ST;
                    end
                end
                DONE_ST: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- counters and results ----------------
    logic gcnt_max, pcnt_max, wcnt_max, count_max;
    assign gcnt_max  = &gcnt_q;
    assign pcnt_max  = &pcnt_q;
    assign wcnt_max  = &wcnt_q;
    assign count_max = &count_q;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            gcnt_q   <= '0;
            pcnt_q   <= '0;
            wcnt_q   <= '0;
            delay_q  <= '0;
            width_q  <= '0;
            period_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b1;
            tout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (soft_rst) begin
            gcnt_q   <= '0;
            pcnt_q   <= '0;
            wcnt_q   <= '0;
            delay_q  <= '0;
            width_q  <= '0;
            period_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b1;
            tout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (arm) begin
            gcnt_q   <= CNT_ONE;
            pcnt_q   <= '0;
            wcnt_q   <= '0;
            delay_q  <= '0;
            width_q  <= '0;
            period_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (state_q != IDLE) begin
            if (!gcnt_max) gcnt_q <= gcnt_q + CNT_ONE;
            // Rise-to-rise counter only runs once a first rise is known.
            if (count_q != '0 && !pcnt_max) pcnt_q <= pcnt_q + CNT_ONE;
            if (state_q == HIGH && !wcnt_max) wcnt_q <= wcnt_q + CNT_ONE;

            if (gcnt_max || (pcnt_max && count_q != '0) ||
                (wcnt_max && state_q == HIGH) || (count_max && rec_rise))
                ovf_q <= 1'b1;

            if (rec_rise) begin
                if (!count_max) count_q <= count_q + 16'd1;
                if (count_q == '0) delay_q  <= gcnt_q;
                else               period_q <= pcnt_q;
                pcnt_q <= CNT_ONE;
                wcnt_q <= CNT_ONE;
            end
            if (rec_fall && count_q == 16'd1) width_q <= wcnt_q;
            if (set_tout) tout_q <= 1'b1;
            if (state_nxt == DONE_ST) done_q <= 1'b1;
        end
    end

    assign BUSY = (state_q != IDLE);

    // ---------------- read back ----------------
    logic [7:0]   status, conf_byte;
    logic [255:0] rd_map;

    always_comb begin
        status            = '0;
        status[STAT_DONE] = done_q;
        status[STAT_TOUT] = tout_q;
        status[STAT_OVF]  = ovf_q;
        conf_byte               = '0;
        conf_byte[CONF_EN_BIT]  = conf_en;
        conf_byte[CONF_INV_BIT] = conf_inv;
    end

    // Byte n of rd_map is register address n; unmapped bytes are zero.
    assign rd_map = {72'd0, count_q, 32'(period_q), 32'(width_q), 32'(delay_q),
                     conf_num, conf_timeout, conf_byte, status, VERSION};

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N)    BUS_DATA_OUT <= '0;
        else if (soft_rst) BUS_DATA_OUT <= '0;
        else if (BUS_RD)   BUS_DATA_OUT <= addr_hit ? rd_map[{addr, 3'b000} +: 8] : 8'd0;
    end

endmodule

// File: tb/tb_pulse_meas_core.sv
// tb_pulse_meas_core
//   Directed bench for pulse_meas_core. Expected values are hand-derived:
//   a START write sampled at edge W arms at W+3; an input changed just after
//   edge c is acted on at c+3, so DELAY = c - W for a pulse raised after c.
module tb_pulse_meas_core;
    import pulse_meas_pkg::*;

    logic        BUS_CLK;
    logic        BUS_RST_N;
    logic [15:0] BUS_ADD;
    logic [7:0]  BUS_DATA_IN;
    logic [7:0]  BUS_DATA_OUT;
    logic        BUS_WR, BUS_RD;
    logic        PULSE_IN, EXT_START;
    logic        BUSY;

    int checks;
    int failures;

    pulse_meas_core #(.ABUSWIDTH(16), .CNT_WIDTH(32)) dut (
        .BUS_CLK      (BUS_CLK),
        .BUS_RST_N    (BUS_RST_N),
        .BUS_ADD      (BUS_ADD),
        .BUS_DATA_IN  (BUS_DATA_IN),
        .BUS_DATA_OUT (BUS_DATA_OUT),
        .BUS_WR       (BUS_WR),
        .BUS_RD       (BUS_RD),
        .PULSE_IN     (PULSE_IN),
        .EXT_START    (EXT_START),
        .BUSY         (BUSY)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Write strobe is sampled on the single posedge between two negedges.
    task automatic bus_write(input int a, input logic [7:0] d);
        @(negedge BUS_CLK);
        BUS_ADD     = 16'(a);
        BUS_DATA_IN = d;
        BUS_WR      = 1'b1;
        @(negedge BUS_CLK);
        BUS_WR      = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [7:0] d);
        @(negedge BUS_CLK);
        BUS_ADD = 16'(a);
        BUS_RD  = 1'b1;
        @(negedge BUS_CLK);
        BUS_RD  = 1'b0;
        d = BUS_DATA_OUT;
    endtask

    task automatic rd(input int a, input int n, output logic [31:0] v);
        logic [7:0] b;
        v = '0;
        for (int i = 0; i < n; i++) begin
            bus_read(a + i, b);
            v[8*i +: 8] = b;
        end
    endtask

    task automatic wr(input int a, input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) bus_write(a + i, v[8*i +: 8]);
    endtask

    initial begin
        logic [31:0] v;
        checks      = 0;
        failures    = 0;
        BUS_RST_N   = 1'b0;
        BUS_ADD     = '0;
        BUS_DATA_IN = '0;
        BUS_WR      = 1'b0;
        BUS_RD      = 1'b0;
        PULSE_IN    = 1'b0;
        EXT_START   = 1'b0;
        repeat (3) @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;

        // ---- reset state ----
        chk("rst_busy", BUSY, 0);
        chk("rst_dout", BUS_DATA_OUT, 0);
        rd(0, 1, v);          chk("rst_version", v, 1);
        rd(1, 1, v);          chk("rst_status", v, 1);
        rd(ADDR_DELAY, 4, v); chk("rst_delay", v, 0);

        // ---- single pulse: DELAY 20, WIDTH 7 ----
        wr(ADDR_NUM, 1, 2);
        bus_write(ADDR_START, 8'h01);       // now just after edge W
        repeat (4) @(negedge BUS_CLK);
        chk("t1_busy_armed", BUSY, 1);
        repeat (16) @(negedge BUS_CLK);     // after W+20
        PULSE_IN = 1'b1;
        repeat (7) @(negedge BUS_CLK);
        PULSE_IN = 1'b0;                    // fall acted at W+30
        repeat (3) @(negedge BUS_CLK);
        chk("t1_busy_done_st", BUSY, 1);
        @(negedge BUS_CLK);
        chk("t1_busy_fall", BUSY, 0);
        rd(ADDR_DELAY, 4, v);  chk("t1_delay", v, 20);
        rd(ADDR_WIDTH, 4, v);  chk("t1_width", v, 7);
        rd(ADDR_PERIOD, 4, v); chk("t1_period", v, 0);
        rd(ADDR_COUNT, 2, v);  chk("t1_count", v, 1);
        rd(1, 1, v);           chk("t1_status", v, 1);

        // ---- pulse train: 4 pulses, width 3, period 10 ----
        wr(ADDR_NUM, 4, 2);
        bus_write(ADDR_START, 8'h01);
        repeat (5) @(negedge BUS_CLK);
        for (int i = 0; i < 4; i++) begin
            PULSE_IN = 1'b1;
            repeat (3) @(negedge BUS_CLK);
            PULSE_IN = 1'b0;
            repeat (7) @(negedge BUS_CLK);
        end
        chk("t2_busy", BUSY, 0);
        rd(ADDR_COUNT, 2, v);  chk("t2_count", v, 4);
        rd(ADDR_WIDTH, 4, v);  chk("t2_width", v, 3);
        rd(ADDR_PERIOD, 4, v); chk("t2_period", v, 10);
        rd(ADDR_DELAY, 4, v);  chk("t2_delay", v, 5);
        rd(1, 1, v);           chk("t2_status", v, 1);

        // ---- timeout 50, no pulses ----
        wr(ADDR_TIMEOUT, 50, 4);
        bus_write(ADDR_START, 8'h01);
        repeat (53) @(negedge BUS_CLK);     // DONE_ST entered at arm+50
        chk("t3_busy_at_50", BUSY, 1);
        @(negedge BUS_CLK);
        chk("t3_busy_at_51", BUSY, 0);
        rd(1, 1, v);          chk("t3_status", v, 3);
        rd(ADDR_COUNT, 2, v); chk("t3_count", v, 0);
        wr(ADDR_TIMEOUT, 0, 4);

        // ---- external arm ----
        bus_write(ADDR_CONF, 8'h00);
        EXT_START = 1'b1;
        repeat (6) @(negedge BUS_CLK);
        chk("t4_ext_disabled", BUSY, 0);
        EXT_START = 1'b0;
        wr(ADDR_NUM, 1, 2);
        bus_write(ADDR_CONF, 8'h01);
        repeat (2) @(negedge BUS_CLK);
        EXT_START = 1'b1;                   // just after edge e
        repeat (5) @(negedge BUS_CLK);
        chk("t4_ext_armed", BUSY, 1);
        EXT_START = 1'b0;
        repeat (10) @(negedge BUS_CLK);     // after e+15
        PULSE_IN = 1'b1;
        repeat (4) @(negedge BUS_CLK);
        PULSE_IN = 1'b0;
        repeat (6) @(negedge BUS_CLK);
        chk("t4_busy", BUSY, 0);
        rd(ADDR_DELAY, 4, v); chk("t4_delay", v, 15);
        bus_write(ADDR_CONF, 8'h00);

        // ---- input already high at arm ----
        PULSE_IN = 1'b1;
        repeat (5) @(negedge BUS_CLK);
        bus_write(ADDR_START, 8'h01);
        repeat (10) @(negedge BUS_CLK);
        PULSE_IN = 1'b0;                    // after W+10
        rd(ADDR_COUNT, 1, v); chk("t5_count_mid", v, 0);
        repeat (3) @(negedge BUS_CLK);
        PULSE_IN = 1'b1;                    // after W+15
        repeat (4) @(negedge BUS_CLK);
        PULSE_IN = 1'b0;
        repeat (6) @(negedge BUS_CLK);
        rd(ADDR_COUNT, 2, v); chk("t5_count", v, 1);
        rd(ADDR_DELAY, 4, v); chk("t5_delay", v, 15);
        rd(ADDR_WIDTH, 4, v); chk("t5_width", v, 4);

        // ---- async reset while in HIGH ----
        bus_write(ADDR_CONF, 8'h01);
        wr(ADDR_TIMEOUT, 200, 4);
        wr(ADDR_NUM, 2, 2);
        bus_write(ADDR_START, 8'h01);
        repeat (5) @(negedge BUS_CLK);
        PULSE_IN = 1'b1;
        repeat (5) @(negedge BUS_CLK);
        rd(0, 1, v);
        chk("t6_busy_high", BUSY, 1);
        chk("t6_dout_pre", BUS_DATA_OUT, 1);
        #2 BUS_RST_N = 1'b0;
        #1;
        chk("t6_busy_async", BUSY, 0);
        chk("t6_dout_async", BUS_DATA_OUT, 0);
        @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;
        PULSE_IN  = 1'b0;
        rd(0, 1, v);            chk("t6_version", v, 1);
        rd(23, 1, v);           chk("t6_addr23", v, 0);
        rd(1, 1, v);            chk("t6_status", v, 1);
        rd(ADDR_CONF, 1, v);    chk("t6_conf", v, 0);
        rd(ADDR_TIMEOUT, 4, v); chk("t6_timeout", v, 0);
        rd(ADDR_NUM, 2, v);     chk("t6_num", v, 0);
        rd(ADDR_COUNT, 2, v);   chk("t6_count", v, 0);
        rd(ADDR_DELAY, 4, v);   chk("t6_delay", v, 0);

        // ---- soft reset mid-measurement ----
        bus_write(ADDR_CONF, 8'h03);
        wr(ADDR_NUM, 5, 2);
        bus_write(ADDR_START, 8'h01);
        repeat (5) @(negedge BUS_CLK);
        chk("t7_busy_pre", BUSY, 1);
        bus_write(ADDR_RESET, 8'h01);
        chk("t7_busy_post", BUSY, 0);
        rd(ADDR_CONF, 1, v); chk("t7_conf", v, 0);
        rd(ADDR_NUM, 2, v);  chk("t7_num", v, 0);
        rd(1, 1, v);         chk("t7_status", v, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
